updw_seq_checker: RTL
=====================

Name: updw_seq_checker

Overview:
- Receive-side checker for the 3-bit up/down triangle counting stream (0,1,…,7,6,…,1,0,1,…) produced by the team's up/down counter FSM.
- Locks onto the stream and infers the count direction. After lock, it predicts each next value and flags deviations.
- Counts completed triangle periods and exposes status to the top level (LEDs/HEX on the board, or a scoreboard in simulation).

Parameters:
- WIDTH, 3, width of the sampled count; MAX = 2**WIDTH-1.
- LOCK_N, 2, consecutive correct predictions required to declare lock (range 1..7).
- PCNT_W, 8, width of the period and error counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- in_valid  input  1  count_in is sampled on a rising clk edge only when high.
- count_in  input  WIDTH  incoming count value.
- locked  output  1  high while in LOCKED state.
- dir_up  output  1  current inferred direction (1 = up); meaningful once match_cnt ≥ 1.
- expected  output  WIDTH  predicted next value; meaningful only when locked.
- err  output  1  one-cycle pulse on a mismatch while locked.
- err_count  output  PCNT_W  number of lock losses; saturates at all-ones.
- period_done  output  1  one-cycle pulse when a full period completes while locked.
- period_count  output  PCNT_W  completed periods; wraps modulo 2**PCNT_W.

Behaviour:
- Reset is asynchronous and active-high, and dominates every other input. All outputs and internal registers go to 0 on reset; state goes to EMPTY.
- Accepted sample: any clk edge with in_valid=1. With in_valid=0 all state holds and the err/period_done pulses deassert.
- All outputs are registered and reflect the sample accepted on the previous edge (latency of 1 clk).
- Prediction function next(v,d):
  - d=1 and v<MAX → v+1; d=1 and v==MAX → MAX-1, with d flipping to 0.
  - d=0 and v>0 → v-1; d=0 and v==0 → 1, with d flipping to 1.
- Registers: last (WIDTH), dir, match_cnt (3 bits), state.
- States and transitions:
  - EMPTY: on a sample, last=count_in and state → FIRST.
  - FIRST: on a sample s:
    - If s==last+1 (last<MAX): dir=1, match_cnt=1, state → TRACK.
    - Else if s==last-1 (last>0): dir=0, match_cnt=1, state → TRACK.
    - Else: stay in FIRST.
    - last=s in all cases.
  - TRACK: on a sample s:
    - If s==next(last,dir): match_cnt++, and dir updates per the next function. When match_cnt reaches LOCK_N the state goes to LOCKED.
    - Else: state → FIRST and match_cnt=0; no err pulse.
    - last=s in all cases.
  - LOCKED: on a sample s:
    - If s==next(last,dir): stay in LOCKED and update dir.
    - Else: err pulses, err_count increments (saturating), state → FIRST with last=s and match_cnt=0. No period is counted on an error sample.
  - With LOCK_N=1, FIRST goes directly to LOCKED on a valid step.
- Direction at the endpoints: in FIRST, dir is inferred from the difference only; the endpoint turnaround is handled by next().
- expected = next(last,dir) whenever locked=1; otherwise 0.
- Period: a matching sample of 0 accepted in LOCKED with previous last==1 and dir=0 pulses period_done and increments period_count (wrapping).
  - No period is counted on the sample that causes lock.
  - A 0 sample arriving while in TRACK is never counted.
- Reset asserted mid-stream: the next sample after deassertion is treated as a first sample (EMPTY → FIRST). There is no period or error carry-over.

Test Plan:
- Lock and track: reset, then feed 0,1,2,…,7,6,…,1,0,1 one per clk with in_valid=1 (LOCK_N=2).
  - locked rises 1 clk after sample "2" is accepted.
  - dir_up=1 up to sample 7; 0 after sample 6.
  - period_done pulses exactly once, 1 clk after the second "0"; period_count=1, err=0 throughout.
- Endpoint turnaround: lock on 5,6,7.
  - expected=6 after sample 7; feeding 6 keeps locked=1 and sets dir_up=0.
- Error: while locked with expected=4 after sample 3, feed 6.
  - err pulses for 1 clk, err_count=1, locked=0.
  - Then feeding 5,4,3 relocks after "4" (locked high 1 clk later); err_count stays 1.
- Valid gaps: while locked, hold in_valid=0 for 5 clks between samples 3 and 4.
  - No state change, no err, expected stays 4 through the gap.
- Bad acquire: feed 2,5,0,1,2.
  - Stays unlocked through 2,5,0; locks after "2". err never pulses.
- Reset mid-operation: assert reset asynchronously between edges while locked with period_count=3.
  - All outputs read 0 immediately.
  - After release, 0,1,2 relocks and period_count restarts from 0.

Source files
------------

// File: rtl/updw_seq_checker.sv
// Receive-side checker for a 3-bit up/down triangle count stream.
// It locks onto the stream, predicts each next value, and counts periods and lock losses.
// Ports:
//   clk, reset (async, active-high)       : clock and reset
//   in_valid, count_in                    : sample strobe and sampled count
//   locked, dir_up, expected              : lock status, inferred direction, predicted next value
//   err, err_count                        : mismatch pulse and saturating lock-loss count
//   period_done, period_count             : period pulse and wrapping period count
module updw_seq_checker #(
  parameter int WIDTH  = 3,
  parameter int LOCK_N = 2,
  parameter int PCNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  count_in,
  output logic              locked,
  output logic              dir_up,
  output logic [WIDTH-1:0]  expected,
  output logic              err,
  output logic [PCNT_W-1:0] err_count,
  output logic              period_done,
  output logic [PCNT_W-1:0] period_count
);

  typedef enum logic [1:0] {
    EMPTY,
    FIRST,
    TRACK,
    LOCKED
  } state_t;

  localparam logic [WIDTH-1:0] MAX    = '1;
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [2:0]       LOCK_C = 3'(LOCK_N);

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    last_q, last_d;
  logic                dir_q, dir_d;
  logic [2:0]          mc_q, mc_d;
  logic                err_q, err_d;
  logic [PCNT_W-1:0]   ec_q, ec_d;
  logic                pd_q, pd_d;
  logic [PCNT_W-1:0]   pc_q, pc_d;

  logic [WIDTH-1:0]    nxt_val;
  logic                nxt_dir;
  logic                match;

  // Prediction from the last accepted sample; turnaround at both ends.
  always_comb begin
    nxt_val = last_q;
    nxt_dir = dir_q;
    if (dir_q) begin
      if (last_q == MAX) begin
        nxt_val = MAX - ONE;
        nxt_dir = 1'b0;
      end else begin
        nxt_val = last_q + ONE;
      end
    end else begin
      if (last_q == '0) begin
        nxt_val = ONE;
        nxt_dir = 1'b1;
      end else begin
        nxt_val = last_q - ONE;
      end
    end
  end

  assign match = (count_in == nxt_val);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    dir_d   = dir_q;
    mc_d    = mc_q;
    err_d   = 1'b0;
    ec_d    = ec_q;
    pd_d    = 1'b0;
    pc_d    = pc_q;
    if (in_valid) begin
      last_d = count_in;
      unique case (state_q)
        EMPTY: state_d = FIRST;
        FIRST: begin
          // Direction comes from the difference alone.
          if (last_q != MAX && count_in == last_q + ONE) begin
            dir_d   = 1'b1;
            mc_d    = 3'd1;
            state_d = (LOCK_C == 3'd1) ? LOCKED : TRACK;
          end else if (last_q != '0 && count_in == last_q - ONE) begin
            dir_d   = 1'b0;
            mc_d    = 3'd1;
            state_d = (LOCK_C == 3'd1) ? LOCKED : TRACK;
          end
        end
        TRACK: begin
          if (match) begin
            mc_d  = mc_q + 3'd1;
            dir_d = nxt_dir;
            if (mc_d == LOCK_C) state_d = LOCKED;
          end else begin
            mc_d    = 3'd0;
            state_d = FIRST;
          end
        end
        LOCKED: begin
          if (match) begin
            dir_d = nxt_dir;
            // Falling 1 -> 0 closes a full triangle.
            if (count_in == '0 && last_q == ONE && !dir_q) begin
              pd_d = 1'b1;
              pc_d = pc_q + 1'b1;
            end
          end else begin
            err_d   = 1'b1;
            ec_d    = (ec_q == '1) ? ec_q : ec_q + 1'b1;
            mc_d    = 3'd0;
            state_d = FIRST;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      last_q  <= '0;
      dir_q   <= 1'b0;
      mc_q    <= 3'd0;
      err_q   <= 1'b0;
      ec_q    <= '0;
      pd_q    <= 1'b0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      dir_q   <= dir_d;
      mc_q    <= mc_d;
      err_q   <= err_d;
      ec_q    <= ec_d;
      pd_q    <= pd_d;
      pc_q    <= pc_d;
    end
  end

  assign locked       = (state_q == LOCKED);
  assign dir_up       = dir_q;
  assign expected     = locked ? nxt_val : '0;
  assign err          = err_q;
  assign err_count    = ec_q;
  assign period_done  = pd_q;
  assign period_count = pc_q;

endmodule
